// File: rtl/teller_dispatch.sv
// teller_dispatch
// ---------------
// Calls the next waiting customer to one of three teller windows and emulates
// the queue's exit photocell so the downstream queue counter sees exactly one
// departure per call.
//
// A teller that finishes a customer (teller_done[i] while its window is open)
// latches a pending request. While the dispatcher is IDLE and the queue is not
// empty, one pending teller is granted in round-robin order. The grant
// produces a one-cycle call_valid, records the teller number, and advances the
// ticket. It also starts an active-low pulse on phcTwo lasting PULSE_LEN
// cycles. phcTwo then stays high for GAP_LEN cycles before the next grant is
// allowed. The gap gives the queue counter time to resynchronise, detect the
// edge and re-register emptyFlag before it is sampled again.
//
// Parameters
//   PULSE_LEN  cycles phcTwo is low per departure (2..15)
//   GAP_LEN    cycles phcTwo is high after a pulse before the next grant (6..15)
//   TICKET_W   width of the served-ticket counter
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   teller_on    in   [2:0] bit i high = teller i+1 window open
//   teller_done  in   [2:0] one-cycle "next customer please" per teller
//   emptyFlag    in   queue-empty flag (registered at its source)
//   phcTwo       out  emulated exit photocell, idle high, low pulse per call
//   Tcount       out  [1:0] number of open tellers
//   call_valid   out  one-cycle pulse per customer called
//   call_teller  out  [1:0] teller number of the latest call, 0 = none yet
//   ticket       out  [TICKET_W-1:0] customers called since reset (wraps)
//   pending      out  [2:0] latched per-teller requests
module teller_dispatch #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 6,
  parameter int TICKET_W  = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [2:0]          teller_on,
  input  logic [2:0]          teller_done,
  input  logic                emptyFlag,
  output logic                phcTwo,
  output logic [1:0]          Tcount,
  output logic                call_valid,
  output logic [1:0]          call_teller,
  output logic [TICKET_W-1:0] ticket,
  output logic [2:0]          pending
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Number of open windows.
  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  // Round-robin pick: search starts at the teller after `last`, order 1->2->3->1.
  // Returns the teller number 1..3, or 0 when nothing is requested.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] pick;
    case (last)
      2'd1:    pick = req[1] ? 2'd2 : (req[2] ? 2'd3 : (req[0] ? 2'd1 : 2'd0));
      2'd2:    pick = req[2] ? 2'd3 : (req[0] ? 2'd1 : (req[1] ? 2'd2 : 2'd0));
      default: pick = req[0] ? 2'd1 : (req[1] ? 2'd2 : (req[2] ? 2'd3 : 2'd0));
    endcase
    return pick;
  endfunction

  // One-hot mask of a teller number (0 gives an empty mask).
  function automatic logic [2:0] teller_mask(input logic [1:0] num);
    logic [2:0] mask;
    case (num)
      2'd1:    mask = 3'b001;
      2'd2:    mask = 3'b010;
      2'd3:    mask = 3'b100;
      default: mask = 3'b000;
    endcase
    return mask;
  endfunction

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [1:0]          last_q, last_d;
  logic                phc_q, phc_d;
  logic [1:0]          tcount_q, tcount_d;
  logic                call_valid_q, call_valid_d;
  logic [1:0]          call_teller_q, call_teller_d;
  logic [TICKET_W-1:0] ticket_q, ticket_d;
  logic [2:0]          pending_q, pending_d;

  logic [2:0]          req_vec;
  logic [1:0]          pick;
  logic [2:0]          grant_vec;

  // Next-state, grant and output computation for the dispatcher.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_d        = last_q;
    phc_d         = phc_q;
    call_valid_d  = 1'b0;
    call_teller_d = call_teller_q;
    ticket_d      = ticket_q;
    grant_vec     = 3'b000;

    // A teller whose window just closed must not be called even if its
    // request bit has not been cleared yet.
    req_vec = pending_q & teller_on;
    pick    = rr_pick(req_vec, last_q);

    case (state_q)
      IDLE: begin
        // emptyFlag only matters here; during PULSE/GAP it is ignored.
        if ((pick != 2'd0) && !emptyFlag) begin
          state_d       = PULSE;
          cnt_d         = 4'(PULSE_LEN - 1);
          phc_d         = 1'b0;
          call_valid_d  = 1'b1;
          call_teller_d = pick;
          last_d        = pick;
          ticket_d      = ticket_q + TICKET_W'(1);
          grant_vec     = teller_mask(pick);
        end else begin
          state_d = IDLE;
          phc_d   = 1'b1;
        end
      end
      PULSE: begin
        if (cnt_q == 4'd0) begin
          state_d = GAP;
          cnt_d   = 4'(GAP_LEN - 1);
          phc_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
          phc_d = 1'b0;
        end
      end
      GAP: begin
        phc_d = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        phc_d   = 1'b1;
      end
    endcase

    // Closing a window wipes its request; a new request arriving on the same
    // cycle as that teller's grant survives the grant.
    pending_d = teller_on & ((pending_q & ~grant_vec) | teller_done);
    tcount_d  = popcount3(teller_on);
  end

  // State and output registers; reset discards any teller_done seen meanwhile.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      last_q        <= 2'd3;
      phc_q         <= 1'b1;
      tcount_q      <= 2'd0;
      call_valid_q  <= 1'b0;
      call_teller_q <= 2'd0;
      ticket_q      <= '0;
      pending_q     <= 3'b000;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_q        <= last_d;
      phc_q         <= phc_d;
      tcount_q      <= tcount_d;
      call_valid_q  <= call_valid_d;
      call_teller_q <= call_teller_d;
      ticket_q      <= ticket_d;
      pending_q     <= pending_d;
    end
  end

  assign phcTwo      = phc_q;
  assign Tcount      = tcount_q;
  assign call_valid  = call_valid_q;
  assign call_teller = call_teller_q;
  assign ticket      = ticket_q;
  assign pending     = pending_q;

endmodule
